// File: rtl/fmm_sequencer.sv
// Control sequencer for an 8x8 matrix product C = A*B built from matrix_ops row operations.
// Rows of A and B are fetched over a request/valid port; finished C rows go out over a write/ready port.
module fmm_sequencer #(
  parameter logic [7:0] A_BASE = 8'd0,
  parameter logic [7:0] B_BASE = 8'd8,
  parameter logic [7:0] C_BASE = 8'd16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         rd_req,
  output logic [7:0]   rd_addr,
  input  logic         rd_valid,
  input  logic [255:0] rd_data,
  output logic         wr_en,
  output logic [7:0]   wr_addr,
  output logic [255:0] wr_data,
  input  logic         wr_ready,
  output logic         mm_en,
  output logic [5:0]   mm_op,
  output logic [255:0] mm_a,
  output logic [255:0] mm_b,
  output logic [255:0] mm_cin,
  input  logic [255:0] mm_co
);

  localparam logic [255:0] ZERO_ROW = {256{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [2:0]     row_r, row_nxt_s;
  logic [2:0]     k_r, k_nxt_s;
  logic [255:0]   a_reg_r, a_nxt_s;
  logic [255:0]   b_reg_r, b_nxt_s;
  logic [255:0]   acc_r, acc_nxt_s;

  logic           busy_r, busy_nxt_s;
  logic           done_r, done_nxt_s;
  logic           rd_req_r, rd_req_nxt_s;
  logic [7:0]     rd_addr_r, rd_addr_nxt_s;
  logic           wr_en_r, wr_en_nxt_s;
  logic [7:0]     wr_addr_r, wr_addr_nxt_s;
  logic [255:0]   wr_data_r, wr_data_nxt_s;
  logic           mm_en_r, mm_en_nxt_s;
  logic [5:0]     mm_op_r, mm_op_nxt_s;

  // Buffer addresses wrap modulo 256 silently.
  function automatic logic [7:0] row_addr(input logic [7:0] base, input logic [2:0] idx);
    return base + {5'd0, idx};
  endfunction

  // Next-state and datapath register updates.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    k_nxt_s     = k_r;
    a_nxt_s     = a_reg_r;
    b_nxt_s     = b_reg_r;
    acc_nxt_s   = acc_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          row_nxt_s   = 3'd0;
          k_nxt_s     = 3'd0;
          acc_nxt_s   = ZERO_ROW;
          state_nxt_s = ST_FETCH_A;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH_A: begin
        if (rd_valid) begin
          a_nxt_s     = rd_data;
          state_nxt_s = ST_FETCH_B;
        end else begin
          state_nxt_s = ST_FETCH_A;
        end
      end
      ST_FETCH_B: begin
        if (rd_valid) begin
          b_nxt_s     = rd_data;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_FETCH_B;
        end
      end
      ST_EXEC: begin
        acc_nxt_s = mm_co;
        if (k_r == 3'd7) begin
          state_nxt_s = ST_WRITE;
        end else begin
          k_nxt_s     = k_r + 3'd1;
          state_nxt_s = ST_FETCH_B;
        end
      end
      ST_WRITE: begin
        if (!wr_ready) begin
          state_nxt_s = ST_WRITE;
        end else if (row_r == 3'd7) begin
          state_nxt_s = ST_DONE;
        end else begin
          row_nxt_s   = row_r + 3'd1;
          k_nxt_s     = 3'd0;
          acc_nxt_s   = ZERO_ROW;
          state_nxt_s = ST_FETCH_A;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered without adding latency.
  always_comb begin
    busy_nxt_s    = 1'b0;
    done_nxt_s    = 1'b0;
    rd_req_nxt_s  = 1'b0;
    rd_addr_nxt_s = 8'd0;
    wr_en_nxt_s   = 1'b0;
    wr_addr_nxt_s = 8'd0;
    wr_data_nxt_s = ZERO_ROW;
    mm_en_nxt_s   = 1'b0;
    mm_op_nxt_s   = 6'd0;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      ST_FETCH_A: begin
        busy_nxt_s    = 1'b1;
        rd_req_nxt_s  = 1'b1;
        rd_addr_nxt_s = row_addr(A_BASE, row_nxt_s);
      end
      ST_FETCH_B: begin
        busy_nxt_s    = 1'b1;
        rd_req_nxt_s  = 1'b1;
        rd_addr_nxt_s = row_addr(B_BASE, k_nxt_s);
      end
      ST_EXEC: begin
        busy_nxt_s  = 1'b1;
        mm_en_nxt_s = 1'b1;
        mm_op_nxt_s = {3'd0, k_nxt_s} + 6'd1;
      end
      ST_WRITE: begin
        busy_nxt_s    = 1'b1;
        wr_en_nxt_s   = 1'b1;
        wr_addr_nxt_s = row_addr(C_BASE, row_nxt_s);
        wr_data_nxt_s = acc_nxt_s;
      end
      ST_DONE: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      row_r     <= 3'd0;
      k_r       <= 3'd0;
      a_reg_r   <= ZERO_ROW;
      b_reg_r   <= ZERO_ROW;
      acc_r     <= ZERO_ROW;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_req_r  <= 1'b0;
      rd_addr_r <= 8'd0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 8'd0;
      wr_data_r <= ZERO_ROW;
      mm_en_r   <= 1'b0;
      mm_op_r   <= 6'd0;
    end else begin
      state_r   <= state_nxt_s;
      row_r     <= row_nxt_s;
      k_r       <= k_nxt_s;
      a_reg_r   <= a_nxt_s;
      b_reg_r   <= b_nxt_s;
      acc_r     <= acc_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      rd_req_r  <= rd_req_nxt_s;
      rd_addr_r <= rd_addr_nxt_s;
      wr_en_r   <= wr_en_nxt_s;
      wr_addr_r <= wr_addr_nxt_s;
      wr_data_r <= wr_data_nxt_s;
      mm_en_r   <= mm_en_nxt_s;
      mm_op_r   <= mm_op_nxt_s;
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign rd_req  = rd_req_r;
  assign rd_addr = rd_addr_r;
  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;
  assign mm_en   = mm_en_r;
  assign mm_op   = mm_op_r;
  assign mm_a    = a_reg_r;
  assign mm_b    = b_reg_r;
  assign mm_cin  = acc_r;

endmodule

// File: tb/tb_fmm_sequencer.sv
// Bench for fmm_sequencer: buffer model with programmable wait states, a matrix_ops lane model,
// and a plain-arithmetic reference product to check every C row.
module tb_fmm_sequencer;

  localparam logic [7:0] A_BASE = 8'd0;
  localparam logic [7:0] B_BASE = 8'd8;
  localparam logic [7:0] C_BASE = 8'd16;
  localparam logic [255:0] SENTINEL = {8{32'hDEAD_BEEF}};

  logic         clk = 1'b0;
  logic         reset, start;
  logic         busy, done, rd_req, rd_valid, wr_en, wr_ready, mm_en;
  logic [7:0]   rd_addr, wr_addr;
  logic [5:0]   mm_op;
  logic [255:0] rd_data, wr_data, mm_a, mm_b, mm_cin, mm_co;

  fmm_sequencer #(.A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mm_en(mm_en), .mm_op(mm_op), .mm_a(mm_a), .mm_b(mm_b), .mm_cin(mm_cin), .mm_co(mm_co)
  );

  always #5 clk = ~clk;

  // matrix_ops lane model: op n adds A-lane (n-1) times each B lane into cin.
  int op_idx;
  always_comb begin
    op_idx = int'(mm_op) - 1;
    mm_co  = mm_cin;
    if (mm_en && op_idx >= 0 && op_idx < 8) begin
      for (int j = 0; j < 8; j++)
        mm_co[32*j +: 32] = mm_cin[32*j +: 32] + mm_a[32*op_idx +: 32] * mm_b[32*j +: 32];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Buffer, reference matrices and activity logs.
  logic [255:0] mem [256];
  logic [31:0]  am [8][8];
  logic [31:0]  bm [8][8];
  logic [31:0]  cm [8][8];
  logic [7:0]   rd_log [$];
  logic [5:0]   op_log [$];
  logic [7:0]   wr_log [$];
  int rd_fix, wr_fix, total_wait, mon_bad;
  bit rnd_mode;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom();
    return r;
  endfunction

  task automatic load_mats(input int kind);
    logic [255:0] ra, rb;
    logic [31:0] s;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        case (kind)
          0: begin am[i][j] = (i == j) ? 32'd1 : 32'd0; bm[i][j] = 32'(i + 1); end
          1: begin am[i][j] = 32'd2; bm[i][j] = 32'd3; end
          default: begin am[i][j] = $urandom(); bm[i][j] = $urandom(); end
        endcase
      end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        ra[32*j +: 32] = am[i][j];
        rb[32*j +: 32] = bm[i][j];
        s = 32'd0;
        for (int k = 0; k < 8; k++) s = s + am[i][k] * bm[k][j];
        cm[i][j] = s;
      end
      mem[A_BASE + 8'(i)] = ra;
      mem[B_BASE + 8'(i)] = rb;
      mem[C_BASE + 8'(i)] = SENTINEL;
    end
  endtask

  // Buffer responder and bus monitor, acting on the falling edge.
  bit rd_active, wr_active;
  int rd_wait, rd_cur, wr_wait, wr_cur;
  logic [7:0] rd_hold, wr_hold_addr;
  logic [255:0] wr_hold_data;
  initial begin
    rd_valid = 1'b0; wr_ready = 1'b0; rd_data = '0;
    rd_active = 0; wr_active = 0; rd_wait = 0; wr_wait = 0; rd_cur = 0; wr_cur = 0;
    forever begin
      @(negedge clk);
      if (rd_req) begin
        if (!rd_active) begin
          rd_active = 1; rd_wait = 0; rd_hold = rd_addr;
          rd_cur = rnd_mode ? int'($urandom_range(2, 0)) : rd_fix;
          total_wait += rd_cur;
        end else if (rd_addr !== rd_hold) mon_bad++;
        if (rd_wait == rd_cur) begin
          rd_valid = 1'b1; rd_data = mem[rd_addr]; rd_log.push_back(rd_addr); rd_active = 0;
        end else begin
          rd_valid = 1'b0; rd_data = rnd256(); rd_wait++;
        end
      end else begin
        rd_active = 0;
        rd_valid = rnd_mode ? ($urandom_range(1, 0) == 1) : 1'b0;
        rd_data = rnd256();
      end
      if (wr_en) begin
        if (!wr_active) begin
          wr_active = 1; wr_wait = 0; wr_hold_addr = wr_addr; wr_hold_data = wr_data;
          wr_cur = rnd_mode ? int'($urandom_range(2, 0)) : wr_fix;
          total_wait += wr_cur;
        end else if (wr_addr !== wr_hold_addr || wr_data !== wr_hold_data) mon_bad++;
        if (wr_wait == wr_cur) begin
          wr_ready = 1'b1; mem[wr_addr] = wr_data; wr_log.push_back(wr_addr); wr_active = 0;
        end else begin
          wr_ready = 1'b0; wr_wait++;
        end
      end else begin
        wr_active = 0;
        wr_ready = rnd_mode ? ($urandom_range(1, 0) == 1) : 1'b0;
      end
      if (mm_en) op_log.push_back(mm_op);
      else if (mm_op !== 6'd0) mon_bad++;
    end
  end

  typedef struct {
    string name;
    int    kind;        // 0 identity, 1 constant 2x3, 2 random
    int    rd_d;
    int    wr_d;
    bit    rnd;         // random wait states and spurious valid/ready
    bit    extra;       // extra start pulses while busy
    int    exp_cycles;  // 0: 145 plus the waits the responder inserted
    int    uni;         // 0 none, 1 lane = row+1, 2 lane = 48
  } vec_t;

  function automatic vec_t mk(input string nm, input int kind, input int rd_d, input int wr_d,
                              input bit rnd, input bit extra, input int exp_c, input int uni);
    vec_t v;
    v.name = nm; v.kind = kind; v.rd_d = rd_d; v.wr_d = wr_d;
    v.rnd = rnd; v.extra = extra; v.exp_cycles = exp_c; v.uni = uni;
    return v;
  endfunction

  task automatic check_reset_outputs(input string p);
    check({p, "_busy"}, busy, 0);       check({p, "_done"}, done, 0);
    check({p, "_rd_req"}, rd_req, 0);   check({p, "_rd_addr"}, rd_addr, 0);
    check({p, "_wr_en"}, wr_en, 0);     check({p, "_wr_addr"}, wr_addr, 0);
    check({p, "_wr_data"}, wr_data, 0); check({p, "_mm_en"}, mm_en, 0);
    check({p, "_mm_op"}, mm_op, 0);     check({p, "_mm_a"}, mm_a, 0);
    check({p, "_mm_b"}, mm_b, 0);       check({p, "_mm_cin"}, mm_cin, 0);
  endtask

  task automatic prep(input vec_t v);
    load_mats(v.kind);
    rd_fix = v.rd_d; wr_fix = v.wr_d; rnd_mode = v.rnd;
    rd_log.delete(); op_log.delete(); wr_log.delete();
    total_wait = 0; mon_bad = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n, bad, extra_done, exp_c;
    bit got_done;
    logic [255:0] exp_row;
    prep(v);
    n = 0; got_done = 0;
    while (!got_done && n < 3000) begin
      @(negedge clk); n++;
      if (n == 1) begin
        check({v.name, "_busy_rise"}, busy, 1);
        check({v.name, "_first_rd"}, {rd_req, rd_addr}, {1'b1, A_BASE});
      end
      start = v.extra && (n == 5 || n == 50 || n == 144);
      if (done) begin
        got_done = 1;
        check({v.name, "_busy_at_done"}, busy, 0);
      end
    end
    start = 1'b0;
    check({v.name, "_done_seen"}, got_done, 1);
    exp_c = (v.exp_cycles != 0) ? v.exp_cycles : 145 + total_wait;
    check({v.name, "_cycles"}, n, exp_c);
    extra_done = 0;
    repeat (20) begin @(negedge clk); if (done) extra_done++; end
    check({v.name, "_single_done"}, extra_done, 0);
    check({v.name, "_idle_busy"}, busy, 0);
    // Read order: A row r, then B rows 0..7, for each r.
    bad = (rd_log.size() == 72) ? 0 : 1;
    for (int i = 0; i < rd_log.size() && i < 72; i++)
      if (rd_log[i] !== ((i % 9 == 0) ? A_BASE + 8'(i / 9) : B_BASE + 8'(i % 9 - 1))) bad++;
    check({v.name, "_rd_seq_errs"}, bad, 0);
    bad = (op_log.size() == 64) ? 0 : 1;
    for (int i = 0; i < op_log.size() && i < 64; i++)
      if (op_log[i] !== 6'(i % 8 + 1)) bad++;
    check({v.name, "_op_seq_errs"}, bad, 0);
    bad = (wr_log.size() == 8) ? 0 : 1;
    for (int i = 0; i < wr_log.size() && i < 8; i++)
      if (wr_log[i] !== C_BASE + 8'(i)) bad++;
    check({v.name, "_wr_seq_errs"}, bad, 0);
    check({v.name, "_bus_errs"}, mon_bad, 0);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) exp_row[32*j +: 32] = cm[i][j];
      check($sformatf("%s_c_row%0d", v.name, i), mem[C_BASE + 8'(i)], exp_row);
      if (v.uni == 1) check($sformatf("%s_uni_row%0d", v.name, i), mem[C_BASE + 8'(i)], {8{32'(i + 1)}});
      if (v.uni == 2) check($sformatf("%s_uni_row%0d", v.name, i), mem[C_BASE + 8'(i)], {8{32'd48}});
    end
  endtask

  vec_t tbl [6];

  initial begin
    int n;
    bit found;
    tbl[0] = mk("identity",  0, 0, 0, 0, 0, 145, 1);
    tbl[1] = mk("backpress", 0, 3, 2, 0, 0, 377, 1);
    tbl[2] = mk("accum",     1, 0, 0, 0, 0, 145, 2);
    tbl[3] = mk("ign_start", 0, 0, 0, 0, 1, 145, 1);
    tbl[4] = mk("rand_wait", 2, 0, 0, 1, 0, 0,   0);
    tbl[5] = mk("rand_data", 2, 0, 0, 0, 0, 145, 0);

    reset = 1'b1; start = 1'b0; rnd_mode = 0; rd_fix = 0; wr_fix = 0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    for (int t = 0; t < 6; t++) run_vec(tbl[t]);

    // Reset while row 3 is fetching B rows: no C row 3 write, then a clean rerun.
    prep(tbl[0]);
    n = 0; found = 0;
    while (!found && n < 1000) begin
      @(negedge clk); n++;
      if (rd_req && rd_addr >= B_BASE && rd_addr < B_BASE + 8'd8 &&
          rd_log.size() >= 29 && rd_log.size() <= 35) found = 1;
    end
    check("midrst_point_found", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_stays_idle", busy, 0);
    check("midrst_wr_count", wr_log.size(), 3);
    check("midrst_no_row3", mem[C_BASE + 8'd3], SENTINEL);
    run_vec(mk("after_rst", 0, 0, 0, 0, 0, 145, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fmm_sequencer.md
# fmm_sequencer

Control sequencer that drives the `matrix_ops` row-operation unit to compute a full 8×8 matrix product C = A·B. It fetches 256-bit rows of A and B from the matrix buffer over a request/valid read port, issues the eight `mm_op` row operations per output row while holding the accumulator, and writes each finished C row back over a write/ready port. It sits between the FMM instruction decode (start/done) and the combinational `matrix_ops` datapath.

## Interface
- `A_BASE`, default 8'd0: buffer row address of A row 0; A row i is at `A_BASE+i`.
- `B_BASE`, default 8'd8: buffer row address of B row 0.
- `C_BASE`, default 8'd16: buffer row address of C row 0.
- `clk` input 1: clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `start` input 1: single-cycle request to begin a multiply; sampled only in IDLE.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse after the last C row write is accepted.
- `rd_req` output 1: read request; held with `rd_addr` stable until `rd_valid`.
- `rd_addr` output 8: buffer row address.
- `rd_valid` input 1: `rd_data` valid; may assert in the same cycle as `rd_req`.
- `rd_data` input 256: row data.
- `wr_en` output 1: write request; held with `wr_addr`/`wr_data` stable until `wr_ready`.
- `wr_addr` output 8, `wr_data` output 256: C row address and data.
- `wr_ready` input 1: write accepted this cycle when `wr_en` high.
- `mm_en` output 1, `mm_op` output 6: enable/opcode to `matrix_ops`.
- `mm_a`, `mm_b`, `mm_cin` output 256 each: operands to `matrix_ops`.
- `mm_co` input 256: result from `matrix_ops`.

## Operation
- Registers: `row` (3 bit), `k` (3 bit), `a_reg`, `b_reg`, `acc` (256 bit each).
- States: IDLE, FETCH_A, FETCH_B, EXEC, WRITE, DONE.
- IDLE: `busy`=0. `start`=1 → `row`=0, `k`=0, `acc`=0, go FETCH_A.
- FETCH_A: `rd_req`=1, `rd_addr`=`A_BASE+row`. On `rd_valid`: `a_reg`←`rd_data`, go FETCH_B.
- FETCH_B: `rd_req`=1, `rd_addr`=`B_BASE+k`. On `rd_valid`: `b_reg`←`rd_data`, go EXEC.
- EXEC: `mm_en`=1, `mm_op`=`k+1`. Capture `acc`←`mm_co`. If `k`==7 go WRITE, else `k`←`k+1`, go FETCH_B.
- WRITE: `wr_en`=1, `wr_addr`=`C_BASE+row`, `wr_data`=`acc`. On `wr_ready`: if `row`==7 go DONE; else `row`←`row+1`, `k`←0, `acc`←0, go FETCH_A.
- DONE: `done`=1 for one cycle, go IDLE.
- `mm_a`=`a_reg`, `mm_b`=`b_reg`, `mm_cin`=`acc` continuously. `mm_en`=0 and `mm_op`=0 outside EXEC, so `matrix_ops` passes `cin` through.
- Arithmetic is entirely in `matrix_ops`. The sequencer stores `mm_co` unmodified (256 bit, no truncation or sign handling).
- `start` while `busy`: ignored, no queueing. `rd_valid` outside FETCH_A/FETCH_B: ignored. `wr_ready` outside WRITE: ignored.
- Address add is 8-bit modulo 256; wrap is not flagged.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_req`=0, `rd_addr`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `mm_en`=0, `mm_op`=0, `mm_a`/`mm_b`/`mm_cin`=0. State is IDLE, all registers 0.
- Reset mid-operation: the next cycle is in IDLE with all outputs at reset values. The partial C row is not written.
- `start` sampled at edge t: `busy`=1 and `rd_req`=1 from t+1.
- Zero-wait memory (`rd_valid`, `wr_ready` same cycle): per row 1 (A) + 8×(1 FETCH_B + 1 EXEC) + 1 WRITE = 18 cycles. Eight rows take 144 cycles, then DONE.
- `done` is high in cycle t+145 and `busy` falls in the same cycle. `start` is accepted again from t+146.
- Each wait cycle on `rd_valid` or `wr_ready` adds exactly one cycle. Request signals stay stable throughout the wait.
- `busy` is 1 in all states except IDLE and DONE.

## Test plan
- Identity: A rows = I (A[i] lane i = 1), B row k lanes all = k+1, zero-wait → C row i lanes all = i+1 at `C_BASE+i`. `done` exactly 145 cycles after `start`, 8 writes total.
- Op sequencing: monitor EXEC cycles → `mm_op` = 1..8 in order per row. `rd_addr` = 0, 8..15, 1, 8..15, … `mm_en`=0 in all non-EXEC cycles.
- Backpressure: `rd_valid` delayed 3 cycles on every read, `wr_ready` delayed 2 → same C data as zero-wait. Total 145 + 72×3 + 8×2 = 377 cycles. `rd_addr`/`wr_data` stable while waiting.
- Accumulation: all A lanes = 2, all B lanes = 3, small values so no lane overflow → every C lane = 48.
- `start` pulsed at cycles 5, 50 and 144 after the first accepted `start` → ignored. Exactly one `done`, and the result matches a single run.
- Reset in row 3 during FETCH_B → next cycle IDLE with all outputs 0 and no write to `C_BASE+3`. A fresh `start` then completes the full product correctly.
